// File: rtl/wshb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wshb_ram_slave
// Purpose  : Wishbone B4 slave fronting a 2**ADDR_W x 32-bit single-port RAM.
//            It supports classic cycles (one ack every two cycles) and
//            incrementing bursts (cti=010) with linear, wrap-4, wrap-8 and
//            wrap-16 address sequencing (zero wait states after the first
//            beat). An access above the memory window terminates with err.
// Ports    : sys_clk      - the only clock
//            sys_rst      - synchronous, active-high reset
//            wshb_cyc/stb - cycle valid / strobe
//            wshb_we      - write enable
//            wshb_adr     - byte address (bits [1:0] ignored)
//            wshb_dat_ms  - write data, master to slave
//            wshb_sel     - byte lane select
//            wshb_cti     - cycle type identifier
//            wshb_bte     - burst type extension
//            wshb_dat_sm  - read data, slave to master (0 outside ack cycles)
//            wshb_ack     - normal termination
//            wshb_err     - error termination (out-of-range address)
//            wshb_rty     - retry, always 0
// Revision : 1.0 - initial release
// ============================================================================
module wshb_ram_slave #(
    parameter int ADDR_W = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wshb_cyc,
    input  logic        wshb_stb,
    input  logic        wshb_we,
    input  logic [31:0] wshb_adr,
    input  logic [31:0] wshb_dat_ms,
    input  logic [3:0]  wshb_sel,
    input  logic [2:0]  wshb_cti,
    input  logic [1:0]  wshb_bte,
    output logic [31:0] wshb_dat_sm,
    output logic        wshb_ack,
    output logic        wshb_err,
    output logic        wshb_rty
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [2:0] CTI_INCR  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLASSIC = 2'd1,
        ST_BURST   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                term_q;
    logic                term_d;
    logic                oor_q;
    logic                oor_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_data;
    logic                req;
    logic                oor_in;
    logic                ack_int;
    logic                unused_adr_lsb;

    assign req            = wshb_cyc & wshb_stb;
    assign oor_in         = (wshb_adr >> (ADDR_W + 2)) != 32'd0;
    assign unused_adr_lsb = ^wshb_adr[1:0];

    // Burst sequencing: bits covered by wrap_mask count up and wrap, the
    // rest of the index is held. Linear bursts use a full mask, which
    // makes the increment wrap modulo the memory depth.
    always_comb begin
        wrap_mask = '1;
        case (wshb_bte)
            2'b01:   wrap_mask = ADDR_W'(4'h3);
            2'b10:   wrap_mask = ADDR_W'(4'h7);
            2'b11:   wrap_mask = ADDR_W'(4'hF);
            default: wrap_mask = '1;
        endcase
        addr_next = (addr_q & ~wrap_mask) | ((addr_q + ADDR_W'(1)) & wrap_mask);
    end

    // Next-state logic. term_q is 1 exactly in the cycles that terminate
    // a beat; it is 0 in every IDLE cycle.
    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        oor_d   = oor_q;
        addr_d  = addr_q;
        if (!wshb_cyc) begin
            state_d = ST_IDLE;
            term_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wshb_stb) begin
                        addr_d  = wshb_adr[ADDR_W+1:2];
                        oor_d   = oor_in;
                        term_d  = 1'b1;
                        state_d = (wshb_cti == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                    end
                end
                ST_CLASSIC: begin
                    term_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_BURST: begin
                    if (wshb_stb && (wshb_cti == CTI_INCR)) begin
                        addr_d = addr_next;
                        term_d = 1'b1;
                    end else begin
                        // End-of-burst, any non-incrementing cti, or a
                        // master wait state: the next strobe restarts
                        // from the address the master presents.
                        term_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    term_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            term_q  <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
        end
    end

    // RAM. The read port is addressed with the next index so data for
    // addr_q is ready in the cycle term_q rises. A write edge always
    // moves the read address elsewhere (burst advance) or is followed by
    // an IDLE cycle that re-reads, so no write-to-read bypass is needed.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && ack_int && wshb_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wshb_sel[b]) begin
                    mem[addr_q][8*b +: 8] <= wshb_dat_ms[8*b +: 8];
                end
            end
        end
        rd_data <= mem[addr_d];
    end

    assign ack_int     = term_q & ~oor_q & req;
    assign wshb_ack    = ack_int;
    assign wshb_err    = term_q & oor_q & req;
    assign wshb_rty    = 1'b0;
    assign wshb_dat_sm = ack_int ? rd_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_wshb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_ram_slave
// Purpose  : Self-checking bench for wshb_ram_slave. A master driver issues
//            classic and burst accesses, pushes the expected termination
//            into a scoreboard queue and updates a word-array reference
//            memory; a monitor pops and compares on every ack/err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_ram_slave;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack, err, rty;

    wshb_ram_slave #(.ADDR_W(ADDR_W)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .wshb_cyc    (cyc),
        .wshb_stb    (stb),
        .wshb_we     (we),
        .wshb_adr    (adr),
        .wshb_dat_ms (dat_ms),
        .wshb_sel    (sel),
        .wshb_cti    (cti),
        .wshb_bte    (bte),
        .wshb_dat_sm (dat_sm),
        .wshb_ack    (ack),
        .wshb_err    (err),
        .wshb_rty    (rty)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [31:0] data;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          tagn   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Word index of beat k: linear wraps over the whole memory, wrap-N
    // stays inside the aligned N-word block containing the start word.
    function automatic int beat_idx(input int start, input logic [1:0] b, input int k);
        int n, base;
        n    = (b == 2'b00) ? DEPTH : (2 << b);
        base = start - (start % n);
        return base + ((start - base + k) % n);
    endfunction

    // Monitor: every termination seen outside reset consumes one entry.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst && (ack || err)) begin
            check("ack_err_exclusive", {31'd0, ack & err}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", ack, err);
            end else begin
                e = sb.pop_front();
                check($sformatf("resp_is_err#%0d", e.tag), {31'd0, err}, {31'd0, e.is_err});
                if (e.chk) check($sformatf("rdata#%0d", e.tag), dat_sm, e.data);
            end
        end
    end

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_ms = '0;
        sel = '0;   cti = '0;   bte = '0;
    endtask

    task automatic wait_resp(output int waited);
        waited = 0;
        @(negedge sys_clk);
        while (!(ack || err) && waited < 10) begin
            waited++;
            @(negedge sys_clk);
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic classic(input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] s);
        exp_t e;
        int   waited, idx;
        bit   oor;
        oor      = (a >> 10) != 0;
        idx      = int'(a[9:2]);
        e.is_err = oor; e.chk = 1'b0; e.data = '0; e.tag = tagn++;
        if (oor)    e.chk = 1'b1;
        else if (w) ref_mem[idx] = merge(ref_mem[idx], d, s);
        else begin  e.chk = 1'b1; e.data = ref_mem[idx]; end
        sb.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s;
        cti = 3'($urandom_range(0, 1)) == 3'd0 ? 3'b000 : 3'b111; bte = '0;
        wait_resp(waited);
        check("classic_latency", 32'(waited), 32'd1);
        @(posedge sys_clk); #1;
        idle_bus();
    endtask

    // Two classic reads with stb held: ack must follow 0,1,0,1.
    task automatic b2b_read(input logic [31:0] a);
        exp_t       e;
        logic [3:0] pat;
        for (int i = 0; i < 2; i++) begin
            e.is_err = 1'b0; e.chk = 1'b1; e.data = ref_mem[int'(a[9:2])]; e.tag = tagn++;
            sb.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; cti = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            pat[i] = ack;
        end
        @(posedge sys_clk); #1;
        idle_bus();
        check("b2b_ack_pattern", {28'd0, pat}, 32'h0000_000A);
    endtask

    // n-beat burst; only the first nb beats are let through before the
    // tail action: 0 normal end, 1 drop cyc, 2 reset, 3 drop stb.
    task automatic burst(input logic [31:0] a, input logic [1:0] b, input int n,
                         input bit w, input int nb, input int abort);
        logic [31:0] wd  [16];
        logic [3:0]  ws  [16];
        int          idx [16];
        int          start, waited;
        bit          oor;
        exp_t        e;
        start = int'(a[9:2]);
        oor   = (a >> 10) != 0;
        for (int k = 0; k < n; k++) begin
            wd[k]  = $urandom;
            ws[k]  = 4'($urandom_range(1, 15));
            idx[k] = beat_idx(start, b, k);
        end
        for (int k = 0; k < nb; k++) begin
            e.is_err = oor; e.chk = !w || oor; e.data = '0; e.tag = tagn++;
            if (!oor) begin
                if (w) ref_mem[idx[k]] = merge(ref_mem[idx[k]], wd[k], ws[k]);
                else   e.data = ref_mem[idx[k]];
            end
            sb.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = w; bte = b;
        for (int k = 0; k < nb; k++) begin
            adr = (a & 32'hFFFF_FC00) | (32'(idx[k]) << 2);
            dat_ms = wd[k]; sel = ws[k];
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            wait_resp(waited);
            check("burst_beat_latency", 32'(waited), (k == 0) ? 32'd1 : 32'd0);
            @(posedge sys_clk); #1;
        end
        if (nb < n) begin
            adr = (a & 32'hFFFF_FC00) | (32'(idx[nb]) << 2);
            dat_ms = wd[nb]; sel = ws[nb];
            cti = (nb == n - 1) ? 3'b111 : 3'b010;
        end
        case (abort)
            1:       cyc = 1'b0;
            2:       sys_rst = 1'b1;
            3:       stb = 1'b0;
            default: idle_bus();
        endcase
        @(negedge sys_clk);
        if (abort != 2) check("burst_tail_no_term", {30'd0, ack, err}, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        idle_bus();
        if (abort == 2) begin
            @(negedge sys_clk);
            check("post_rst_ack_err", {30'd0, ack, err}, 32'd0);
            check("post_rst_dat_sm", dat_sm, 32'd0);
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic read_words(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) classic(32'((first + i) % DEPTH) << 2, 1'b0, '0, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rty", {31'd0, rty}, 32'd0);
        check("reset_dat_sm", dat_sm, 32'd0);
        @(posedge sys_clk); #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) classic(32'(i) << 2, 1'b1, $urandom, 4'hF);

        // Classic write/read and byte lanes.
        classic(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        classic(32'h10, 1'b0, '0, 4'h0);
        classic(32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF);
        classic(32'h20, 1'b1, 32'h1122_3344, 4'b0101);
        classic(32'h23, 1'b0, '0, 4'h0);
        b2b_read(32'h20);

        // Linear and wrapping bursts.
        for (int i = 0; i < 8; i++) classic(32'(i) << 2, 1'b1, 32'(i), 4'hF);
        burst(32'h08, 2'b00, 4, 1'b0, 4, 0);
        burst(32'h38, 2'b01, 4, 1'b0, 4, 0);
        burst(32'h5C, 2'b10, 8, 1'b1, 8, 0);
        burst(32'h50, 2'b10, 8, 1'b0, 8, 0);
        burst(32'hF8, 2'b11, 16, 1'b1, 16, 0);
        burst(32'hC0, 2'b11, 16, 1'b0, 16, 0);
        burst(32'h3F8, 2'b00, 4, 1'b0, 4, 0);

        // Out of range.
        classic(32'h400, 1'b1, 32'hCAFE_F00D, 4'hF);
        classic(32'h400, 1'b0, '0, 4'h0);
        burst(32'h1000, 2'b00, 3, 1'b1, 3, 0);
        read_words(0, 1);

        // Aborts: cyc drop, reset, master wait.
        burst(32'h80, 2'b00, 8, 1'b1, 2, 1);
        read_words(32, 4);
        burst(32'hA0, 2'b00, 8, 1'b1, 2, 2);
        read_words(40, 4);
        burst(32'hC0, 2'b00, 8, 1'b1, 3, 3);
        read_words(48, 4);

        // Randomised mix.
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            int          op;
            op = $urandom_range(0, 3);
            a  = {22'd0, 8'($urandom), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
            case (op)
                0:       classic(a, 1'b1, $urandom, 4'($urandom));
                1:       classic(a, 1'b0, '0, 4'h0);
                2:       burst(a, 2'($urandom), $urandom_range(1, 8), 1'b1, 0, 0);
                default: burst(a, 2'($urandom), $urandom_range(1, 8), 1'b0, 0, 0);
            endcase
        end

        repeat (4) @(posedge sys_clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
